// File: rtl/dm_dmi_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_dmi_responder
// Purpose  : Debug-module end of the DMI link. Accepts dmi_req_t requests,
//            services a small DM register set (data0, data1, dmcontrol,
//            dmstatus, hartinfo), drives hart-control request lines and
//            queues dmi_resp_t responses in a FIFO so the DTM can issue
//            back-to-back operations.
// Ports    : clk_i/rst_ni          clock, async active-low reset
//            dmi_req_*             request channel {addr[6:0],data[31:0],op[1:0]}
//            dmi_resp_*            response channel {data[31:0],resp[1:0]}
//            dmactive_o/ndmreset_o dmcontrol[0]/[1]
//            haltreq_o             dmcontrol[31] level
//            resumereq_o           one-cycle resume pulse
//            allhalted_i/allrunning_i  hart status, reflected in dmstatus
// Revision : 1.0 - initial release
// ============================================================================
module dm_dmi_responder #(
    parameter int unsigned RespDepth = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    input  logic [40:0] dmi_req_i,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    output logic [33:0] dmi_resp_o,
    output logic        dmactive_o,
    output logic        ndmreset_o,
    output logic        haltreq_o,
    output logic        resumereq_o,
    input  logic        allhalted_i,
    input  logic        allrunning_i
);

    localparam int unsigned c_PTR_W = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned c_CNT_W = $clog2(RespDepth + 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(RespDepth);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(RespDepth - 1);

    localparam logic [1:0] c_OP_READ   = 2'h1;
    localparam logic [1:0] c_OP_WRITE  = 2'h2;
    localparam logic [1:0] c_OP_BAD    = 2'h3;
    localparam logic [1:0] c_RESP_OK   = 2'h0;
    localparam logic [1:0] c_RESP_FAIL = 2'h2;

    localparam logic [6:0] c_ADDR_DATA0     = 7'h04;
    localparam logic [6:0] c_ADDR_DATA1     = 7'h05;
    localparam logic [6:0] c_ADDR_DMCONTROL = 7'h10;
    localparam logic [6:0] c_ADDR_DMSTATUS  = 7'h11;

    // Register state
    logic [31:0] r_data0;
    logic [31:0] r_data1;
    logic        r_dmactive;
    logic        r_ndmreset;
    logic        r_haltreq;
    logic        r_resumereq;

    // Response FIFO state
    logic [33:0]        r_fifo_mem [RespDepth];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Request decode
    logic [6:0]  w_req_addr;
    logic [31:0] w_req_data;
    logic [1:0]  w_req_op;
    logic        w_accept;
    logic        w_pop;
    logic        w_write;
    logic [31:0] w_dmcontrol;
    logic [31:0] w_dmstatus;
    logic [31:0] w_rdata;
    logic [33:0] w_resp_entry;
    logic [c_PTR_W-1:0] w_wr_ptr_nxt;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;

    assign w_req_addr = dmi_req_i[40:34];
    assign w_req_data = dmi_req_i[33:2];
    assign w_req_op   = dmi_req_i[1:0];

    // Ready depends only on the registered occupancy, never on resp_ready.
    assign dmi_req_ready_o = (r_count != c_FULL);
    assign w_accept        = dmi_req_valid_i & dmi_req_ready_o;
    assign w_pop           = dmi_resp_valid_o & dmi_resp_ready_i;
    assign w_write         = w_accept & (w_req_op == c_OP_WRITE);

    // Bit 30 (resumereq) is write-only and always reads back as 0.
    assign w_dmcontrol = {r_haltreq, 1'b0, 28'd0, r_ndmreset, r_dmactive};
    // version=2, authenticated=1, any/all halted and any/all running mirrored.
    assign w_dmstatus  = {20'd0, allrunning_i, allrunning_i, allhalted_i,
                          allhalted_i, 1'b1, 3'd0, 4'd2};

    always_comb begin
        w_rdata = 32'd0;
        unique case (w_req_addr)
            c_ADDR_DATA0:     w_rdata = r_data0;
            c_ADDR_DATA1:     w_rdata = r_data1;
            c_ADDR_DMCONTROL: w_rdata = w_dmcontrol;
            c_ADDR_DMSTATUS:  w_rdata = w_dmstatus;
            default:          w_rdata = 32'd0;
        endcase
    end

    always_comb begin
        w_resp_entry = {32'd0, c_RESP_OK};
        if (w_req_op == c_OP_READ) begin
            w_resp_entry = {w_rdata, c_RESP_OK};
        end else if (w_req_op == c_OP_BAD) begin
            w_resp_entry = {32'd0, c_RESP_FAIL};
        end
    end

    // Register file and hart-control lines
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data0     <= 32'd0;
            r_data1     <= 32'd0;
            r_dmactive  <= 1'b0;
            r_ndmreset  <= 1'b0;
            r_haltreq   <= 1'b0;
            r_resumereq <= 1'b0;
        end else begin
            r_resumereq <= 1'b0;
            if (w_write) begin
                unique case (w_req_addr)
                    c_ADDR_DATA0: if (r_dmactive) r_data0 <= w_req_data;
                    c_ADDR_DATA1: if (r_dmactive) r_data1 <= w_req_data;
                    c_ADDR_DMCONTROL: begin
                        r_dmactive <= w_req_data[0];
                        // While inactive only bit 0 is writable, so enabling
                        // the DM never takes effect on the other bits.
                        if (r_dmactive) begin
                            if (w_req_data[0]) begin
                                r_haltreq  <= w_req_data[31];
                                r_ndmreset <= w_req_data[1];
                            end else begin
                                r_haltreq  <= 1'b0;
                                r_ndmreset <= 1'b0;
                                r_data0    <= 32'd0;
                                r_data1    <= 32'd0;
                            end
                            // haltreq takes priority over resumereq.
                            r_resumereq <= w_req_data[30] & ~w_req_data[31];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Response FIFO
    assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

    // Storage needs no reset: the output is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_fifo_mem[r_wr_ptr] <= w_resp_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_pop)    r_rd_ptr <= w_rd_ptr_nxt;
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign dmi_resp_valid_o = (r_count != '0);
    assign dmi_resp_o       = dmi_resp_valid_o ? r_fifo_mem[r_rd_ptr] : 34'd0;

    assign dmactive_o  = r_dmactive;
    assign ndmreset_o  = r_ndmreset;
    assign haltreq_o   = r_haltreq;
    assign resumereq_o = r_resumereq;

endmodule
`default_nettype wire

// File: tb/tb_dm_dmi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_dmi_responder
// Purpose  : Self-checking bench for dm_dmi_responder. A transaction-level
//            model (register variables plus a response queue) predicts every
//            observable output; directed scenarios and a randomized run are
//            compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_dmi_responder;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [40:0] req;
    logic        resp_valid;
    logic        resp_ready;
    logic [33:0] resp;
    logic        dmactive, ndmreset, haltreq, resumereq;
    logic        allhalted, allrunning;

    dm_dmi_responder #(.RespDepth(DEPTH)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .dmi_req_valid_i  (req_valid),
        .dmi_req_ready_o  (req_ready),
        .dmi_req_i        (req),
        .dmi_resp_valid_o (resp_valid),
        .dmi_resp_ready_i (resp_ready),
        .dmi_resp_o       (resp),
        .dmactive_o       (dmactive),
        .ndmreset_o       (ndmreset),
        .haltreq_o        (haltreq),
        .resumereq_o      (resumereq),
        .allhalted_i      (allhalted),
        .allrunning_i     (allrunning)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_data0, m_data1;
    bit          m_act, m_ndm, m_halt, m_resume;
    bit          m_acc;
    logic [33:0] m_q[$];

    wire [39:0] dut_vec = {req_ready, resp_valid, resp, dmactive, ndmreset, haltreq, resumereq};

    function automatic logic [39:0] exp_vec();
        logic [33:0] head;
        head = 34'd0;
        if (m_q.size() != 0) head = m_q[0];
        return {m_q.size() < DEPTH, m_q.size() != 0, head, m_act, m_ndm, m_halt, m_resume};
    endfunction

    task automatic model_reset();
        m_data0 = 0; m_data1 = 0;
        m_act = 0; m_ndm = 0; m_halt = 0; m_resume = 0; m_acc = 0;
        m_q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [6:0] a);
        logic [31:0] v;
        v = 0;
        case (a)
            7'h04: v = m_data0;
            7'h05: v = m_data1;
            7'h10: v = (m_halt ? 32'h8000_0000 : 0) + (m_ndm ? 32'h2 : 0) + (m_act ? 32'h1 : 0);
            7'h11: v = 32'h82 + (allhalted ? 32'h300 : 0) + (allrunning ? 32'hC00 : 0);
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [31:0] d);
        case (a)
            7'h04: if (m_act) m_data0 = d;
            7'h05: if (m_act) m_data1 = d;
            7'h10: begin
                if (!m_act) begin
                    m_act = d[0];
                end else begin
                    m_resume = d[30] && !d[31];
                    m_act    = d[0];
                    if (d[0]) begin
                        m_halt = d[31];
                        m_ndm  = d[1];
                    end else begin
                        m_halt = 0; m_ndm = 0; m_data0 = 0; m_data1 = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // Advance one clock, updating the model with what the edge will do.
    task automatic tick();
        logic [33:0] e;
        bit acc, pop;
        acc = req_valid && (m_q.size() < DEPTH);
        pop = resp_ready && (m_q.size() != 0);
        m_acc = acc;
        m_resume = 0;
        e = 34'd0;
        if (acc) begin
            case (req[1:0])
                2'd1: e = {model_read(req[40:34]), 2'd0};
                2'd2: model_write(req[40:34], req[33:2]);
                2'd3: e = {32'd0, 2'd2};
                default: ;
            endcase
        end
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req = {a, d, op};
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1;
        n_chk++;
        if (dut_vec !== 40'h80_0000_0000) $display("FAIL reset_asserted: got %h expected %h", dut_vec, 40'h80_0000_0000);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        n_chk++;
        if (dut_vec !== exp_vec()) $display("FAIL reset_released: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_enable();
        resp_ready = 0;
        drive(2'd2, 7'h10, 32'h1); tick();
        drive(2'd1, 7'h10, 32'h0); tick();
        idle();
        n_chk++;
        if (dut_vec !== exp_vec() || resp !== 34'd0 || dmactive !== 1'b1)
            $display("FAIL enable_first_resp: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
        resp_ready = 1; tick();
        n_chk++;
        if (resp !== {32'h1, 2'd0} || dut_vec !== exp_vec())
            $display("FAIL enable_read_resp: got %h expected %h", resp, {32'h1, 2'd0});
        else n_pass++;
        tick();
        n_chk++;
        if (resp_valid !== 1'b0 || dut_vec !== exp_vec())
            $display("FAIL enable_drained: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    task automatic test_gating();
        resp_ready = 1;
        drive(2'd2, 7'h10, 32'h0);         tick();
        drive(2'd2, 7'h04, 32'hDEAD_BEEF); tick();
        drive(2'd1, 7'h04, 32'h0);         tick();
        idle();
        n_chk++;
        if (resp !== 34'd0 || dut_vec !== exp_vec())
            $display("FAIL gated_data0: got %h expected %h", resp, 34'd0);
        else n_pass++;
        drive(2'd2, 7'h10, 32'h1);         tick();
        drive(2'd2, 7'h04, 32'hDEAD_BEEF); tick();
        drive(2'd1, 7'h04, 32'h0);         tick();
        idle();
        n_chk++;
        if (resp !== {32'hDEAD_BEEF, 2'd0} || dut_vec !== exp_vec())
            $display("FAIL active_data0: got %h expected %h", resp, {32'hDEAD_BEEF, 2'd0});
        else n_pass++;
        tick();
    endtask

    task automatic test_resume_halt();
        resp_ready = 1;
        drive(2'd2, 7'h10, 32'h4000_0001); tick();
        idle();
        n_chk++;
        if (resumereq !== 1'b1 || dut_vec !== exp_vec())
            $display("FAIL resume_pulse: got %b expected %b", resumereq, 1'b1);
        else n_pass++;
        tick();
        n_chk++;
        if (resumereq !== 1'b0 || dut_vec !== exp_vec())
            $display("FAIL resume_one_cycle: got %b expected %b", resumereq, 1'b0);
        else n_pass++;
        drive(2'd2, 7'h10, 32'hC000_0001); tick();
        idle();
        n_chk++;
        if (haltreq !== 1'b1 || resumereq !== 1'b0 || dut_vec !== exp_vec())
            $display("FAIL halt_wins: got halt=%b resume=%b expected halt=1 resume=0", haltreq, resumereq);
        else n_pass++;
        tick();
    endtask

    task automatic test_status_fail();
        resp_ready = 1;
        allhalted = 1; allrunning = 0;
        drive(2'd1, 7'h11, 32'h0); tick();
        n_chk++;
        if (resp !== {32'h382, 2'd0} || dut_vec !== exp_vec())
            $display("FAIL dmstatus_read: got %h expected %h", resp, {32'h382, 2'd0});
        else n_pass++;
        drive(2'd3, 7'h04, $urandom); tick();
        n_chk++;
        if (resp !== {32'h0, 2'd2} || dut_vec !== exp_vec())
            $display("FAIL op3_resp: got %h expected %h", resp, {32'h0, 2'd2});
        else n_pass++;
        drive(2'd1, 7'h04, 32'h0); tick();
        idle();
        n_chk++;
        if (resp !== {32'hDEAD_BEEF, 2'd0} || dut_vec !== exp_vec())
            $display("FAIL op3_no_effect: got %h expected %h", resp, {32'hDEAD_BEEF, 2'd0});
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [6:0] addrs [3];
        int k;
        bit done;
        addrs[0] = 7'h04; addrs[1] = 7'h05; addrs[2] = 7'h10;
        resp_ready = 1;
        drive(2'd2, 7'h05, 32'h1234_5678); tick();
        idle(); tick();
        k = 0;
        done = 0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (k < 3) drive(2'd1, addrs[k], 32'h0); else idle();
            resp_ready = (cyc >= 4);
            tick();
            if (m_acc) k++;
            n_chk++;
            if (dut_vec !== exp_vec()) $display("FAIL backpressure_cyc%0d: got %h expected %h", cyc, dut_vec, exp_vec());
            else n_pass++;
            if (cyc == 3) begin
                n_chk++;
                if (req_ready !== 1'b0 || k != 2)
                    $display("FAIL ready_drop: got ready=%b accepts=%0d expected ready=0 accepts=2", req_ready, k);
                else n_pass++;
            end
            done = (k == 3) && (m_q.size() == 0);
        end
        idle();
        n_chk++;
        if (k != 3 || resp_valid !== 1'b0)
            $display("FAIL backpressure_drain: got accepts=%0d valid=%b expected accepts=3 valid=0", k, resp_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [6:0] a;
        logic [31:0] d;
        int sel;
        for (int i = 0; i < 400; i++) begin
            allhalted  = $urandom_range(0, 1);
            allrunning = $urandom_range(0, 1);
            resp_ready = ($urandom_range(0, 9) < 6);
            sel = $urandom_range(0, 6);
            case (sel)
                0: a = 7'h04; 1: a = 7'h05; 2, 3: a = 7'h10;
                4: a = 7'h11; 5: a = 7'h12; default: a = 7'($urandom);
            endcase
            d = $urandom;
            if (a == 7'h10 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            if ($urandom_range(0, 3) != 0) begin
                sel = $urandom_range(0, 7);
                drive((sel < 3) ? 2'd1 : (sel < 6) ? 2'd2 : (sel == 6) ? 2'd0 : 2'd3, a, d);
            end else begin
                idle();
            end
            tick();
            n_chk++;
            if (dut_vec !== exp_vec()) $display("FAIL random_cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_async_reset();
        resp_ready = 0;
        drive(2'd2, 7'h10, 32'h1); tick();
        drive(2'd1, 7'h10, 32'h0); tick();
        idle();
        n_chk++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0 || dut_vec !== exp_vec())
            $display("FAIL pre_reset_queue: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (dut_vec !== 40'h80_0000_0000)
            $display("FAIL async_reset: got %h expected %h", dut_vec, 40'h80_0000_0000);
        else n_pass++;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1;
        tick();
        n_chk++;
        if (dut_vec !== exp_vec()) $display("FAIL post_reset: got %h expected %h", dut_vec, exp_vec());
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req = '0; resp_ready = 0;
        allhalted = 0; allrunning = 0;
        model_reset();
        test_reset();
        test_enable();
        test_gating();
        test_resume_halt();
        test_status_fail();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/dm_dmi_responder.md
# dm_dmi_responder

Debug-module side of the DMI link: it terminates `dmi_req_t` requests issued by the DTM and returns `dmi_resp_t` responses. It holds a minimal DM register set (data0, data1, dmcontrol, dmstatus, hartinfo), drives the hart-control request lines, and buffers responses in a small FIFO so the DTM can issue back-to-back ops. It sits between the DTM's DMI initiator and the hart/SBA control logic inside the debug module.

## Interface
- `RespDepth`, 2: response FIFO depth; legal values are ≥1.
- `clk_i` input, 1 bit: the single clock.
- `rst_ni` input, 1 bit: asynchronous, active-low reset.
- `dmi_req_valid_i` input, 1 bit: request valid.
- `dmi_req_ready_o` output, 1 bit: request accepted when valid and ready are both high.
- `dmi_req_i` input, 41 bits: `dmi_req_t` packed as {addr[6:0], data[31:0], op[1:0]}.
- `dmi_resp_valid_o` output, 1 bit: response valid.
- `dmi_resp_ready_i` input, 1 bit: DTM consumes the response.
- `dmi_resp_o` output, 34 bits: `dmi_resp_t` packed as {data[31:0], resp[1:0]}.
- `dmactive_o` output, 1 bit: dmcontrol[0].
- `ndmreset_o` output, 1 bit: dmcontrol[1].
- `haltreq_o` output, 1 bit: dmcontrol[31], level.
- `resumereq_o` output, 1 bit: one-cycle pulse.
- `allhalted_i` input, 1 bit: hart halted status.
- `allrunning_i` input, 1 bit: hart running status.

## Operation
- Register map:
  - 0x04 data0 (RW).
  - 0x05 data1 (RW).
  - 0x10 dmcontrol: only bits 31, 30, 1 and 0 are implemented; bit 30 is write-only and reads 0.
  - 0x11 dmstatus (RO): bits[3:0]=2, bit7=1, bit8=bit9=`allhalted_i`, bit10=bit11=`allrunning_i`, all other bits 0.
  - 0x12 hartinfo (RO): reads 0.
- Op decode, applied on the accept edge:
  - DTM_READ: response data = current register value; resp=0.
  - DTM_WRITE: register updated; response data=0; resp=0.
  - DTM_NOP: no register effect; response data=0; resp=0.
  - op=2'h3: no register effect; response data=0; resp=2 (failed).
- Unmapped addresses: a read returns data 0 with resp 0; a write is ignored with resp 0. Writes to RO registers are also ignored with resp 0.
- dmactive gating: while dmcontrol[0]=0, data0, data1 and dmcontrol bits 31 and 1 are held at 0. A write to dmcontrol while dmactive=0 updates only bit 0. A write that sets bit 0 and other bits together applies bit 0 only; the other bits need a second write.
- `resumereq_o` pulses high for exactly the one cycle after a dmcontrol write with bit30=1, bit31=0 and dmactive already 1. With bit31=1 in the same write, haltreq wins and no pulse is produced.
- Every accepted request, NOP included, pushes exactly one response into the FIFO. Responses leave in request order.

## Timing
- Reset values: all registers 0; FIFO empty; `dmi_req_ready_o`=1; `dmi_resp_valid_o`=0; `dmi_resp_o`=0; `dmactive_o`=`ndmreset_o`=`haltreq_o`=`resumereq_o`=0.
- `dmi_req_ready_o` = (FIFO count != RespDepth). It is registered-derived: there is no combinational path from `dmi_resp_ready_i`.
- Latency: a request accepted on edge N has its response visible on `dmi_resp_o` with `dmi_resp_valid_o`=1 after edge N, provided the FIFO was empty. Register and output side effects are visible after the same edge N.
- `dmi_resp_valid_o` = FIFO not empty. `dmi_resp_o` shows the FIFO head and stays stable while valid is high and ready is low.
- Simultaneous push and pop in one cycle:
  - FIFO neither empty nor full: count unchanged.
  - FIFO empty: the new entry becomes the head next cycle.
  - FIFO full: push is impossible because ready=0.
- A read of a register in the same cycle as an accepted write to it cannot occur (one request per cycle). A read on the cycle after a write returns the new value.
- Status inputs are sampled at the accept edge of the dmstatus read.
- Reset asserted mid-operation: FIFO is flushed and registers cleared asynchronously; pending responses are discarded.

## Test plan
- Reset, then write 0x10 = 0x0000_0001, then read 0x10 → two responses in order: {0,0} and then {0x0000_0001,0}; `dmactive_o`=1.
- With dmactive=0, write 0x04 = 0xDEAD_BEEF, then read 0x04 → read returns 0; then set dmactive, repeat the write and read → read returns 0xDEAD_BEEF.
- With dmactive=1, write 0x10 = 0x4000_0001 → `resumereq_o` high for exactly one cycle; a later write of 0xC000_0001 → `haltreq_o`=1 and no resumereq pulse.
- Drive `allhalted_i`=1 and `allrunning_i`=0, then read 0x11 → data 0x0000_0382, resp 0. Issue op=3 to 0x04 → resp 2, data0 unchanged.
- Hold `dmi_resp_ready_i`=0 and issue 3 reads with RespDepth=2 → `dmi_req_ready_o` drops after 2 accepts; releasing ready drains the responses in order and the third request is then accepted.
- Assert `rst_ni` low while 2 responses are queued → `dmi_resp_valid_o`=0 and all outputs return to 0 immediately, without waiting for a clock edge.
